sdram_port_arbiter: RTL

Two-client arbiter that shares the 32 MB SDRAM controller between the N64 cartridge-bus read path (client 0) and the host loader path (client 1). It owns the controller's write port and read port, serializes one transaction at a time, applies fixed priority with a starvation guard, and aborts transactions the controller never acknowledges. It sits between the cartridge/loader logic and the SDRAM controller instance, replacing the free-running counter stimulus used on the test bench.

---
 rtl/sdram_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-client SDRAM controller arbiter: one transaction at a time, client 0 priority
// with a starvation guard for client 1, and abort of transactions never acknowledged.
module sdram_port_arbiter #(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        c0_req,
   input  logic        c0_we,
   input  logic [31:0] c0_addr,
   input  logic [15:0] c0_wdata,
   output logic        c0_ack,
   output logic [15:0] c0_rdata,
   output logic        c0_err,

   input  logic        c1_req,
   input  logic        c1_we,
   input  logic [31:0] c1_addr,
   input  logic [15:0] c1_wdata,
   output logic        c1_ack,
   output logic [15:0] c1_rdata,
   output logic        c1_err,

   output logic        writeport_wr,
   output logic [31:0] writeport_addr,
   output logic [15:0] writeport_data,
   input  logic        writeport_ack,

   output logic        readport_rd,
   output logic [31:0] readport_addr,
   input  logic [15:0] readport_data,
   input  logic        readport_ack,

   output logic        busy,
   output logic        grant
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_ONE = TW'(1);
   localparam logic [SW-1:0] STV_MAX = SW'(STARVE_LIMIT);
   localparam logic [SW-1:0] STV_ONE = SW'(1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e        state_q, state_d;
   logic          grant_q, grant_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic          wr_n_q, wr_n_d;
   logic          rd_n_q, rd_n_d;
   logic [31:0]   wr_addr_q, wr_addr_d;
   logic [15:0]   wr_data_q, wr_data_d;
   logic [31:0]   rd_addr_q, rd_addr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [15:0]   c0_rdata_q, c0_rdata_d;
   logic [15:0]   c1_rdata_q, c1_rdata_d;

   logic          pick1;
   logic          sel_we;
   logic [31:0]   sel_addr;
   logic [15:0]   sel_wdata;
   logic          port_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_addr_q  <= '0;
         tmo_q      <= '0;
         starve_q   <= '0;
         c0_rdata_q <= '0;
         c1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         we_q       <= we_d;
         err_q      <= err_d;
         wr_n_q     <= wr_n_d;
         rd_n_q     <= rd_n_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_addr_q  <= rd_addr_d;
         tmo_q      <= tmo_d;
         starve_q   <= starve_d;
         c0_rdata_q <= c0_rdata_d;
         c1_rdata_q <= c1_rdata_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      we_d       = we_q;
      err_d      = err_q;
      wr_n_d     = wr_n_q;
      rd_n_d     = rd_n_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_addr_d  = rd_addr_q;
      tmo_d      = tmo_q;
      starve_d   = starve_q;
      c0_rdata_d = c0_rdata_q;
      c1_rdata_d = c1_rdata_q;
      pick1      = !c0_req || (c1_req && (starve_q == STV_MAX));
      sel_we     = pick1 ? c1_we    : c0_we;
      sel_addr   = pick1 ? c1_addr  : c0_addr;
      sel_wdata  = pick1 ? c1_wdata : c0_wdata;
      // Only the issued port's ack counts; the other port may carry stray pulses.
      port_ack   = we_q ? writeport_ack : readport_ack;

      case (state_q)
         IDLE: begin
            if (c0_req || c1_req) begin
               grant_d = pick1;
               we_d    = sel_we;
               err_d   = 1'b0;
               tmo_d   = '0;
               if (sel_we) begin
                  wr_n_d    = 1'b0;
                  wr_addr_d = sel_addr;
                  wr_data_d = sel_wdata;
               end else begin
                  rd_n_d    = 1'b0;
                  rd_addr_d = sel_addr;
               end
               if (!pick1 && c1_req)
                  starve_d = (starve_q == STV_MAX) ? starve_q : starve_q + STV_ONE;
               else
                  starve_d = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (port_ack) begin
               wr_n_d = 1'b1;
               rd_n_d = 1'b1;
               if (!we_q) begin
                  if (grant_q) c1_rdata_d = readport_data;
                  else         c0_rdata_d = readport_data;
               end
               state_d = RESP;
            end else if (tmo_q + TMO_ONE == TMO_MAX) begin
               wr_n_d = 1'b1;
               rd_n_d = 1'b1;
               err_d  = 1'b1;
               if (grant_q) c1_rdata_d = '0;
               else         c0_rdata_d = '0;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      c0_ack         = (state_q == RESP) && !grant_q;
      c1_ack         = (state_q == RESP) &&  grant_q;
      c0_err         = c0_ack && err_q;
      c1_err         = c1_ack && err_q;
      c0_rdata       = c0_rdata_q;
      c1_rdata       = c1_rdata_q;
      writeport_wr   = wr_n_q;
      writeport_addr = wr_addr_q;
      writeport_data = wr_data_q;
      readport_rd    = rd_n_q;
      readport_addr  = rd_addr_q;
      busy           = (state_q != IDLE);
      grant          = grant_q;
   end

endmodule
